// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one req/ack data-memory transaction per
// load/store, shapes store lanes, extends load data and registers the W-stage retire.
module mem_access_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_M,
    input  logic        is_load_M,
    input  logic        is_store_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] store_data_M,
    output logic        stall_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] data_load_ext_W,
    output logic        wb_valid_W,
    output logic        misalign_err_W,
    output logic        timeout_err,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ldata_q, ldata_d;
    logic        wbv_q, wbv_d;
    logic        mis_q, mis_d;
    logic        tout_q, tout_d;

    logic        is_mem;
    logic        misaligned;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] rd_shift;
    logic [31:0] ld_ext;

    // funct3[1:0]: 00 byte, 01 half, anything else treated as a word access.
    always_comb begin
        is_mem     = is_load_M | is_store_M;
        misaligned = ((funct3_M[1:0] == 2'b01) && addr_M[0]) ||
                     (funct3_M[1] && (addr_M[1:0] != 2'b00));
        case (funct3_M[1:0])
            2'b00: begin
                st_mask = 4'b0001 << addr_M[1:0];
                st_data = {4{store_data_M[7:0]}};
            end
            2'b01: begin
                st_mask = addr_M[1] ? 4'b1100 : 4'b0011;
                st_data = {2{store_data_M[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = store_data_M;
            end
        endcase
    end

    // Byte/half lanes are selected by shifting the read word down by the latched offset.
    always_comb begin
        rd_shift = dmem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
            3'b101:  ld_ext = {16'd0, rd_shift[15:0]};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        off_d   = off_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        ldata_d = ldata_q;
        wbv_d   = 1'b0;
        mis_d   = 1'b0;
        tout_d  = tout_q;
        stall_M = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_M) begin
                    if (!is_mem) begin
                        wbv_d   = 1'b1;
                        ldata_d = 32'd0;
                    end else if (misaligned) begin
                        wbv_d   = 1'b1;
                        mis_d   = 1'b1;
                        ldata_d = 32'd0;
                    end else begin
                        stall_M = 1'b1;
                        req_d   = 1'b1;
                        we_d    = is_store_M;
                        addr_d  = {addr_M[31:2], 2'b00};
                        wmask_d = is_store_M ? st_mask : 4'b0000;
                        wdata_d = is_store_M ? st_data : 32'd0;
                        off_d   = addr_M[1:0];
                        f3_d    = funct3_M;
                        cnt_d   = 8'd0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_M = !dmem_ack;
                // An ack on the timeout cycle still completes the transaction.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    wbv_d   = 1'b1;
                    ldata_d = we_q ? 32'd0 : ld_ext;
                    state_d = IDLE;
                end else if (cnt_q + 8'd1 == 8'(MAX_WAIT)) begin
                    cnt_d   = cnt_q + 8'd1;
                    req_d   = 1'b0;
                    tout_d  = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ERR: begin
                stall_M = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            cnt_q   <= 8'd0;
            ldata_q <= 32'd0;
            wbv_q   <= 1'b0;
            mis_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            ldata_q <= ldata_d;
            wbv_q   <= wbv_d;
            mis_q   <= mis_d;
            tout_q  <= tout_d;
        end
    end

    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;
    assign dmem_wmask      = wmask_q;
    assign data_load_ext_W = ldata_q;
    assign wb_valid_W      = wbv_q;
    assign misalign_err_W  = mis_q;
    assign timeout_err     = tout_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout,
// reset behaviour and a zero-wait pipelined instruction stream.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_M, is_load_M, is_store_M;
    logic [2:0]  funct3_M;
    logic [31:0] addr_M, store_data_M;
    logic        stall_M, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] data_load_ext_W;
    logic        wb_valid_W, misalign_err_W, timeout_err;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .valid_M(valid_M), .is_load_M(is_load_M), .is_store_M(is_store_M),
        .funct3_M(funct3_M), .addr_M(addr_M), .store_data_M(store_data_M),
        .stall_M(stall_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .data_load_ext_W(data_load_ext_W), .wb_valid_W(wb_valid_W),
        .misalign_err_W(misalign_err_W), .timeout_err(timeout_err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        valid_M = v; is_load_M = ld; is_store_M = st; funct3_M = f3;
        addr_M = a; store_data_M = sd;
    endtask

    // Issue one aligned memory op with the ack arriving in BUSY cycle k.
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int k,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data);
        int stalls;
        stalls = 0;
        drive(1'b1, ld, st, f3, a, sd);
        dmem_ack = 1'b0;
        #1;
        if (stall_M) stalls++;
        check({tag, "_req_t0"}, 32'(dmem_req), 32'd0);
        tick();
        check({tag, "_req"}, 32'(dmem_req), 32'd1);
        check({tag, "_we"}, 32'(dmem_we), 32'(st));
        check({tag, "_addr"}, dmem_addr, exp_addr);
        check({tag, "_wmask"}, 32'(dmem_wmask), 32'(exp_mask));
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        for (int i = 1; i < k; i++) begin
            if (stall_M) stalls++;
            tick();
        end
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        #1;
        check({tag, "_stall_ack"}, 32'(stall_M), 32'd0);
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check({tag, "_stalls"}, 32'(stalls), 32'(k));
        check({tag, "_wbv"}, 32'(wb_valid_W), 32'd1);
        check({tag, "_data"}, data_load_ext_W, exp_data);
        check({tag, "_mis"}, 32'(misalign_err_W), 32'd0);
        check({tag, "_req_done"}, 32'(dmem_req), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall_M), 32'd0);
        check({tag, "_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_wmask"}, 32'(dmem_wmask), 32'd0);
        check({tag, "_data"}, data_load_ext_W, 32'd0);
        check({tag, "_wbv"}, 32'(wb_valid_W), 32'd0);
        check({tag, "_mis"}, 32'(misalign_err_W), 32'd0);
        check({tag, "_tout"}, 32'(timeout_err), 32'd0);
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
    } instr_t;

    instr_t prog[4];
    logic   exp_stall[7];
    logic   exp_wbv[7];
    logic [31:0] exp_q[$];

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // LW, ack in the third BUSY cycle.
        mem_op("lw", 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 3, 32'hDEADBEEF,
               32'h100, 4'b0000, 32'd0, 32'hDEADBEEF);
        tick();
        check("lw_wbv_clear", 32'(wb_valid_W), 32'd0);

        mem_op("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h80FF_0000,
               32'h100, 4'b0000, 32'd0, 32'hFFFFFF80);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 2, 32'h80FF_0000,
               32'h100, 4'b0000, 32'd0, 32'h00000080);
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 1, 32'h80FF_0000,
               32'h100, 4'b0000, 32'd0, 32'h000080FF);
        mem_op("lh", 1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 1, 32'h80FF_0000,
               32'h100, 4'b0000, 32'd0, 32'hFFFF80FF);
        mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 2, 32'hFFFFFFFF,
               32'h200, 4'b0010, 32'h78787878, 32'd0);
        mem_op("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 1, 32'hFFFFFFFF,
               32'h200, 4'b1100, 32'h56785678, 32'd0);
        // Ack on the cycle the wait counter reaches MAX_WAIT wins over timeout.
        mem_op("lw_edge", 1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 4, 32'hCAFEF00D,
               32'h104, 4'b0000, 32'd0, 32'hCAFEF00D);
        check("lw_edge_tout", 32'(timeout_err), 32'd0);

        // Non-memory op retires next edge with zero data.
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0);
        #1;
        check("add_stall", 32'(stall_M), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("add_wbv", 32'(wb_valid_W), 32'd1);
        check("add_data", data_load_ext_W, 32'd0);

        // Misaligned LH: no request, retire with misalign flag.
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h101, 32'd0);
        #1;
        check("mis_stall", 32'(stall_M), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_wbv", 32'(wb_valid_W), 32'd1);
        check("mis_flag", 32'(misalign_err_W), 32'd1);
        check("mis_data", data_load_ext_W, 32'd0);
        tick();
        check("mis_wbv_clear", 32'(wb_valid_W), 32'd0);
        check("mis_flag_clear", 32'(misalign_err_W), 32'd0);

        // Misaligned SW also retires without a request.
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h206, 32'h1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("missw_req", 32'(dmem_req), 32'd0);
        check("missw_flag", 32'(misalign_err_W), 32'd1);

        // Reset in the middle of BUSY abandons the transaction.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'd0);
        tick();
        check("rstbusy_req", 32'(dmem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstbusy_req_drop", 32'(dmem_req), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rstbusy_wbv", 32'(wb_valid_W), 32'd0);
        check("rstbusy_state", 32'(state_o), 32'd0);

        // Timeout with no ack and MAX_WAIT = 4.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
        dmem_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("to_req_c%0d", i), 32'(dmem_req), 32'd1);
        end
        tick();
        check("to_req_drop", 32'(dmem_req), 32'd0);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_stall", 32'(stall_M), 32'd1);
        check("to_wbv", 32'(wb_valid_W), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("to_stall_hold", 32'(stall_M), 32'd1);
        check("to_req_hold", 32'(dmem_req), 32'd0);
        check("to_err_hold", 32'(timeout_err), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("to_rst");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Zero-wait memory: ADD, LW, SW, ADD with an upstream that advances on !stall_M.
        prog[0] = '{ld: 1'b0, st: 1'b0, f3: 3'b000, a: 32'h0,   sd: 32'h0};
        prog[1] = '{ld: 1'b1, st: 1'b0, f3: 3'b010, a: 32'h100, sd: 32'h0};
        prog[2] = '{ld: 1'b0, st: 1'b1, f3: 3'b010, a: 32'h104, sd: 32'hA5A5A5A5};
        prog[3] = '{ld: 1'b0, st: 1'b0, f3: 3'b000, a: 32'h0,   sd: 32'h0};
        exp_stall = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_wbv   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_q = '{32'd0, 32'h11223344, 32'd0, 32'd0};
        dmem_ack = 1'b1;
        dmem_rdata = 32'h11223344;
        begin
            int idx;
            logic stall_seen;
            idx = 0;
            for (int c = 0; c < 7; c++) begin
                if (idx < 4)
                    drive(1'b1, prog[idx].ld, prog[idx].st, prog[idx].f3, prog[idx].a, prog[idx].sd);
                else
                    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
                #1;
                stall_seen = stall_M;
                check($sformatf("zw_stall_c%0d", c), 32'(stall_M), 32'(exp_stall[c]));
                tick();
                check($sformatf("zw_wbv_c%0d", c), 32'(wb_valid_W), 32'(exp_wbv[c]));
                if (wb_valid_W) begin
                    if (exp_q.size() == 0) begin
                        check("zw_extra_retire", 32'd1, 32'd0);
                    end else begin
                        check($sformatf("zw_data_c%0d", c), data_load_ext_W, exp_q.pop_front());
                    end
                end
                if (!stall_seen && idx < 4) idx++;
            end
            check("zw_all_retired", 32'(exp_q.size()), 32'd0);
        end
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        n_fail++;
        $display("FAIL watchdog expired at time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
